counter_4_bit: RTL and testbench

Free-running synchronous binary up-counter, 4 bits wide by default, that increments once per clock and wraps from its maximum value to zero. It serves as a general-purpose cycle counter or timebase in the datapath. Optional status outputs flag the terminal count and the wrap event for downstream logic.

---
 rtl/counter_4_bit.sv | 44 ++++
 tb/tb_counter_4_bit.sv | 92 +++++++++
 2 files changed

// File: rtl/counter_4_bit.sv
// Free-running modulo-2^WIDTH up-counter with a terminal-count decode and a
// registered one-cycle wrap pulse marking the cycle after rollover.
module counter_4_bit #(
  parameter int                 WIDTH       = 4,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] count,
  output logic             terminal,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [WIDTH-1:0] count_p0;
  logic             wrap_p0;

  // Unsigned modulo increment; the carry out of the top bit is simply dropped.
  function automatic logic [WIDTH-1:0] inc_mod(input logic [WIDTH-1:0] v);
    return v + ONE;
  endfunction

  function automatic logic at_max(input logic [WIDTH-1:0] v);
    return v == ALL_ONES;
  endfunction

  // Stage p0: counter state and rollover flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_p0 <= RESET_VALUE;
      wrap_p0  <= 1'b0;
    end else begin
      count_p0 <= inc_mod(count_p0);
      wrap_p0  <= at_max(count_p0);
    end
  end

  assign count    = count_p0;
  assign wrap     = wrap_p0;
  assign terminal = at_max(count_p0);

endmodule

// File: tb/tb_counter_4_bit.sv
// Randomized-reset bench for counter_4_bit across several WIDTH/RESET_VALUE
// configurations, checked against a cycles-since-reset reference model.
module tb_counter_4_bit;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  logic [3:0] c4;  logic t4;  logic w4;
  logic [0:0] c1;  logic t1;  logic w1;
  logic [7:0] c8;  logic t8;  logic w8;
  logic [3:0] c4r; logic t4r; logic w4r;

  counter_4_bit u4 (.clk(clk), .rst(rst), .count(c4), .terminal(t4), .wrap(w4));
  counter_4_bit #(.WIDTH(1)) u1 (.clk(clk), .rst(rst), .count(c1), .terminal(t1), .wrap(w1));
  counter_4_bit #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .count(c8), .terminal(t8), .wrap(w8));
  counter_4_bit #(.WIDTH(4), .RESET_VALUE(4'd13)) u4r (.clk(clk), .rst(rst), .count(c4r), .terminal(t4r), .wrap(w4r));

  int n_chk  = 0;
  int n_fail = 0;
  longint k  = 0;   // rising edges since the last reset edge

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (k=%0d, t=%0t)", tag, obs, exp, k, $time);
    end
  endtask

  function automatic longint exp_count(input int w, input longint rv);
    return (rv + k) % (longint'(1) << w);
  endfunction

  task automatic check_one(input string name, input int w, input longint rv,
                           input logic [31:0] c, input logic t, input logic wr);
    longint e;
    longint mx;
    e  = exp_count(w, rv);
    mx = (longint'(1) << w) - 1;
    check({name, ".count"},    c,  32'(e));
    check({name, ".terminal"}, {31'd0, t},  {31'd0, e == mx});
    check({name, ".wrap"},     {31'd0, wr}, {31'd0, (k > 0) && (e == 0)});
  endtask

  task automatic check_all();
    check_one("w4",    4, 0,  {28'd0, c4},  t4,  w4);
    check_one("w1",    1, 0,  {31'd0, c1},  t1,  w1);
    check_one("w8",    8, 0,  {24'd0, c8},  t8,  w8);
    check_one("w4rv13", 4, 13, {28'd0, c4r}, t4r, w4r);
  endtask

  // Apply rst for one rising edge, advance the model, then check at the falling edge.
  task automatic step(input logic r);
    rst = r;
    @(posedge clk);
    if (r) k = 0;
    else   k = k + 1;
    @(negedge clk);
    check_all();
  endtask

  initial begin
    @(negedge clk);
    step(1'b1);
    step(1'b1);
    step(1'b1);

    // Long uninterrupted run covers the 256-cycle period of the 8-bit instance.
    for (int i = 0; i < 300; i++) step(1'b0);

    // Reset while the default instance sits at all-ones: no wrap pulse expected.
    for (int i = 0; i < 20 && (k % 16) != 15; i++) step(1'b0);
    check("w4.at_max_before_reset", {28'd0, c4}, 32'd15);
    step(1'b1);
    check("w4.reset_at_max_wrap", {31'd0, w4}, 32'd0);
    step(1'b0);
    check("w4.resume_after_reset", {28'd0, c4}, 32'd1);

    // Random short resets interleaved with counting.
    for (int i = 0; i < 800; i++) step($urandom_range(0, 99) < 4);

    // Multi-edge reset holds count at RESET_VALUE.
    for (int i = 0; i < 3; i++) step(1'b1);
    for (int i = 0; i < 40; i++) step(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
